// File: rtl/pulp_clock_divider_cfg.sv
// rtl/pulp_clock_divider_cfg.sv - configurable integer clock divider with ratio handshake
//
// Purpose:
//   Divides clk_i by a runtime-programmable integer ratio N (2..2^DIV_WIDTH-1).
//   The divided clock is high for floor(N/2) source cycles, then low for
//   ceil(N/2) cycles. Ratio changes and enable changes take effect only at
//   period boundaries, so the output never carries a truncated pulse.
//
// Ports:
//   clk_i        in   source clock (only clock in the block)
//   rst_i        in   asynchronous active-high reset
//   en_i         in   divider enable, sampled at period boundaries
//   test_mode_i  in   DFT bypass: clk_o follows clk_i
//   div_i        in   requested ratio (DIV_WIDTH bits)
//   div_valid_i  in   ratio request, held until div_ack_o
//   div_ack_o    out  one-cycle pulse on request acceptance
//   running_o    out  high while the divider is in RUN
//   clk_o        out  divided clock (or clk_i in test mode)

module pulp_clock_divider_cfg #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 test_mode_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ack_o,
    output logic                 running_o,
    output logic                 clk_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clk_q, clk_d;
    logic                 ack_q, ack_d;

    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] div_last;
    logic [DIV_WIDTH-1:0] div_half;
    logic                 wrap;
    logic                 accept;

    // cnt_q never exceeds div_q-1 <= 2^DIV_WIDTH-2, so the increment cannot overflow.
    assign cnt_inc  = cnt_q + ONE;
    assign div_last = div_q - ONE;
    assign div_half = div_q >> 1;

    // Last cycle of the current period: the only point where the ratio or
    // the enable may change while running.
    assign wrap = (state_q == RUN) && (cnt_q == div_last);

    // ack_q gates re-acceptance so a request still held during its ack
    // cycle is not taken twice.
    assign accept = div_valid_i && !ack_q && ((state_q == IDLE) || wrap);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        div_d   = div_q;
        ack_d   = accept;

        // Ratios below 2 cannot produce a clock; clamp them to 2.
        if (accept) begin
            div_d = (div_i >= DIV_MIN) ? div_i : DIV_MIN;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en_i) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (en_i) begin
                        // New period starts high; it uses div_d, which
                        // already holds any ratio accepted on this edge.
                        clk_d = 1'b1;
                    end else begin
                        clk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < div_half);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= DIV_RST;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            ack_q   <= ack_d;
        end
    end

    assign div_ack_o = ack_q;
    assign running_o = (state_q == RUN);

    // Single clock mux; clk_q is a flop output so the functional path is glitch-free.
    assign clk_o = test_mode_i ? clk_i : clk_q;

endmodule

// File: tb/tb_pulp_clock_divider_cfg.sv
// tb/tb_pulp_clock_divider_cfg.sv - self-checking bench for pulp_clock_divider_cfg

module tb_pulp_clock_divider_cfg;

    localparam int DW   = 8;
    localparam int DDIV = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          test_mode_i = 1'b0;
    logic [DW-1:0] div_i = '0;
    logic          div_valid_i = 1'b0;
    logic          div_ack_o;
    logic          running_o;
    logic          clk_o;

    int checks = 0;
    int errors = 0;

    pulp_clock_divider_cfg #(
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .test_mode_i(test_mode_i),
        .div_i      (div_i),
        .div_valid_i(div_valid_i),
        .div_ack_o  (div_ack_o),
        .running_o  (running_o),
        .clk_o      (clk_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a period is described by its start cycle and ratio;
    // the expected output is derived from elapsed cycles since that start.
    int cyc     = 0;
    int m_start = 0;
    int m_ratio = DDIV;
    int m_div   = DDIV;
    bit m_run   = 1'b0;
    bit m_ack   = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_run   <= 1'b0;
            m_ack   <= 1'b0;
            m_div   <= DDIV;
            m_ratio <= DDIV;
        end else begin
            bit at_end;
            bit acc;
            int nd;
            at_end = m_run && ((cyc - m_start) == m_ratio - 1);
            acc    = div_valid_i && !m_ack && (!m_run || at_end);
            nd     = acc ? ((int'(div_i) >= 2) ? int'(div_i) : 2) : m_div;
            if (!m_run) begin
                if (en_i) begin
                    m_run   <= 1'b1;
                    m_start <= cyc + 1;
                    m_ratio <= nd;
                end
            end else if (at_end) begin
                if (en_i) begin
                    m_start <= cyc + 1;
                    m_ratio <= nd;
                end else begin
                    m_run <= 1'b0;
                end
            end
            m_div <= nd;
            m_ack <= acc;
            cyc   <= cyc + 1;
        end
    end

    always @(negedge clk_i) begin
        logic exp_clk;
        if ($time > 6) begin
            exp_clk = test_mode_i ? clk_i : (m_run && ((cyc - m_start) < (m_ratio / 2)));
            check("clk_o", 32'(clk_o), 32'(exp_clk));
            check("running_o", 32'(running_o), 32'(m_run));
            check("div_ack_o", 32'(div_ack_o), 32'(m_ack));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic capture(input int n, output logic [31:0] v);
        v = '0;
        repeat (n) begin
            @(negedge clk_i);
            #1;
            v = {v[30:0], clk_o};
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!div_ack_o && n < 10);
    endtask

    initial begin
        logic [31:0] v;
        int n;

        tick();
        tick();
        check("reset_clk_o", 32'(clk_o), 0);
        check("reset_running_o", 32'(running_o), 0);
        check("reset_div_ack_o", 32'(div_ack_o), 0);

        // reset then enable: default ratio 2
        rst_i = 1'b0;
        tick();
        en_i = 1'b1;
        tick();
        check("enable_running_latency", 32'(running_o), 1);
        capture(6, v);
        check("ratio2_wave", v, 32'b101010);
        tick();
        en_i = 1'b0;
        repeat (4) tick();

        // odd ratio from IDLE
        div_i = 8'd5;
        div_valid_i = 1'b1;
        tick();
        check("idle_ack_latency", 32'(div_ack_o), 1);
        div_valid_i = 1'b0;
        en_i = 1'b1;
        tick();
        check("ack_single_pulse", 32'(div_ack_o), 0);
        capture(10, v);
        check("ratio5_wave", v, 32'b1100011000);
        tick();
        en_i = 1'b0;
        repeat (12) tick();

        // simultaneous enable and request in IDLE, then update in RUN at cnt 1
        div_i = 8'd4;
        div_valid_i = 1'b1;
        en_i = 1'b1;
        tick();
        check("idle_ack_with_enable", 32'(div_ack_o), 1);
        div_valid_i = 1'b0;
        tick();
        div_i = 8'd6;
        div_valid_i = 1'b1;
        wait_ack(n);
        check("run_ack_latency", 32'(n), 3);
        div_valid_i = 1'b0;
        capture(12, v);
        check("ratio6_wave", v, 32'b111000111000);
        tick();
        en_i = 1'b0;
        repeat (14) tick();

        // saturation of 0 and 1, with no re-acceptance during ack
        div_i = 8'd0;
        div_valid_i = 1'b1;
        tick();
        check("sat0_ack", 32'(div_ack_o), 1);
        tick();
        check("held_valid_not_reaccepted", 32'(div_ack_o), 0);
        div_valid_i = 1'b0;
        div_i = 8'd1;
        div_valid_i = 1'b1;
        tick();
        check("sat1_ack", 32'(div_ack_o), 1);
        div_valid_i = 1'b0;
        en_i = 1'b1;
        tick();
        check("sat_running", 32'(running_o), 1);
        capture(6, v);
        check("sat_wave", v, 32'b101010);
        tick();

        // disable mid-period at ratio 8
        div_i = 8'd8;
        div_valid_i = 1'b1;
        wait_ack(n);
        check("ratio8_acked", 32'(div_ack_o), 1);
        div_valid_i = 1'b0;
        tick();
        tick();
        en_i = 1'b0;
        capture(10, v);
        check("disable_wave", v, 32'b1100000000);
        check("disable_running_off", 32'(running_o), 0);

        // async reset in the high phase, with test mode toggled
        tick();
        en_i = 1'b1;
        tick();
        tick();
        check("pre_reset_high", 32'(clk_o), 1);
        rst_i = 1'b1;
        #1;
        check("reset_drops_clk", 32'(clk_o), 0);
        check("reset_drops_running", 32'(running_o), 0);
        test_mode_i = 1'b1;
        #1;
        check("bypass_high", 32'(clk_o), 1);
        #2;
        check("bypass_low", 32'(clk_o), 0);
        test_mode_i = 1'b0;
        tick();
        check("in_reset_ack", 32'(div_ack_o), 0);
        rst_i = 1'b0;
        tick();
        check("post_reset_running", 32'(running_o), 1);
        capture(6, v);
        check("post_reset_ratio2_wave", v, 32'b101010);

        tick();
        en_i = 1'b0;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulp_clock_divider_cfg.md
PULP_CLOCK_DIVIDER_CFG -- requirements
Module: pulp_clock_divider_cfg

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 8: width of the division-ratio field.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 2: ratio loaded at reset; legal range 2..2^DIV_WIDTH-1.
REQ-003 The block SHALL have port clk_i, input, 1 bit: source clock, the only clock in the block.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port en_i, input, 1 bit: divider enable, sampled at period boundaries.
REQ-006 The block SHALL have port test_mode_i, input, 1 bit: DFT bypass, clk_o = clk_i.
REQ-007 The block SHALL have port div_i, input, DIV_WIDTH bits: requested ratio.
REQ-008 The block SHALL have port div_valid_i, input, 1 bit: ratio request; held by the upstream until div_ack_o.
REQ-009 The block SHALL have port div_ack_o, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-010 The block SHALL have port running_o, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port clk_o, output, 1 bit: divided clock, which feeds the downstream clock inverter.

Function
REQ-012 State SHALL be held in registers div_q, cnt_q (DIV_WIDTH bits each), clk_q and ack_q, with FSM states IDLE and RUN; all registers SHALL clock on the rising edge of clk_i.
REQ-013 clk_o SHALL equal clk_i when test_mode_i=1 and clk_q otherwise, through a single clock mux; clk_o SHALL have no other combinational path.
REQ-014 div_ack_o SHALL equal ack_q; ack_q SHALL be high for exactly one cycle after each acceptance.
REQ-015 In IDLE: clk_q=0 and cnt_q=0.
REQ-016 In IDLE with en_i=1: next state SHALL be RUN, with cnt_q<=0 and clk_q<=1 (period start).
REQ-017 A request SHALL be accepted when div_valid_i=1 and ack_q=0, and either (state IDLE) or (state RUN and cnt_q==div_q-1).
REQ-018 On acceptance: div_q<=div_i if div_i>=2, else div_q<=2 (saturation), and ack_q<=1.
REQ-019 In RUN when cnt_q!=div_q-1: cnt_q<=cnt_q+1 and clk_q<=((cnt_q+1) < (div_q>>1)).
REQ-020 In RUN when cnt_q==div_q-1 (wrap) with en_i=1: cnt_q<=0 and clk_q<=1; the new period SHALL use the ratio accepted in the same cycle, if any.
REQ-021 In RUN at wrap with en_i=0: next state SHALL be IDLE and clk_q<=0.
REQ-022 en_i changes outside wrap SHALL be ignored; a period always completes.
REQ-023 Resulting waveform for ratio N: high for floor(N/2) cycles, then low for ceil(N/2) cycles; period N cycles of clk_i.
REQ-024 Acceptance latency SHALL be 1 cycle in IDLE and at most div_q cycles in RUN; div_q SHALL never change mid-period.
REQ-025 Simultaneous en_i=1 and an accepted request in IDLE: div_q SHALL be loaded, and RUN SHALL start on the same edge using the new ratio.
REQ-026 A request with div_valid_i still high in the ack_q=1 cycle SHALL NOT be re-accepted.
REQ-027 running_o SHALL be 1 exactly when the state is RUN.
REQ-028 test_mode_i SHALL NOT affect the FSM, counter or handshake.

Reset
REQ-029 While rst_i=1, the block SHALL asynchronously force: state IDLE, cnt_q=0, clk_q=0, ack_q=0, div_q=DEFAULT_DIV, div_ack_o=0, running_o=0, clk_o=0 (test_mode_i=0).
REQ-030 Reset asserted mid-period SHALL drop clk_o low immediately and discard any pending request.
REQ-031 After deassertion, the first period SHALL start on the first rising edge of clk_i with en_i=1.

Verification
REQ-032 Scenario "reset then enable": release reset, en_i=1, no request -> clk_o toggles 1 high / 1 low (ratio 2); running_o=1 one cycle after en_i.
REQ-033 Scenario "odd ratio": in IDLE, div_i=5, div_valid_i=1 -> ack pulses the next cycle; after enabling, clk_o is 2 cycles high and 3 low, period 5.
REQ-034 Scenario "update in RUN": running at ratio 4, request div_i=6 at cnt_q=1 -> ack at the wrap (2 cycles later), and the next period is 3 high / 3 low with no truncated pulse.
REQ-035 Scenario "saturation": div_i=0 and then div_i=1 -> each is acked, div_q=2 and clk_o runs at ratio 2.
REQ-036 Scenario "disable mid-period": ratio 8, en_i=0 at cnt_q=2 -> the period completes (4 high / 4 low), then clk_o stays 0 and running_o=0.
REQ-037 Scenario "async reset": rst_i pulsed mid-high-phase with test_mode_i toggled -> clk_o is 0 immediately (clk_i while test_mode_i=1), and div_q returns to 2.
